fetch_stage: RTL and testbench

Instruction-fetch stage: owns the PC, issues requests to instruction memory over a valid/ready request channel with an in-order response channel, buffers returned instructions in a small prefetch FIFO, and drives the IF/ID pipeline register. It sits directly upstream of the decode stage. It consumes the stall and flush controls from the hazard unit (`pc_write`, `retain_if_id`, `flush_if_id`) and the taken-branch/jump redirect from EX/MEM.

---
 rtl/fetch_stage_if.sv | 37 +++
 rtl/fetch_stage.sv | 212 +++++++++++++++++++++
 tb/tb_fetch_stage.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage_if
// Description : Instruction-memory bus between the fetch stage and memory.
//               A valid/ready request channel carries the fetch address.
//               A response channel returns instruction words in order and
//               cannot be back-pressured.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_stage_if #(
    parameter int XLEN = 32
);
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;

    // Fetch side: issues requests and consumes responses.
    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data
    );

    // Memory side: accepts requests and produces responses.
    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data
    );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction-fetch stage. It owns the PC and issues fetches
//               under a credit limit of DEPTH (in flight + buffered). It tags
//               in-flight requests with their PC and buffers responses in a
//               prefetch FIFO. It drives the IF/ID register under hazard
//               stall/flush control and EX/MEM redirects. Responses to
//               requests issued before a redirect are counted and discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    fetch_stage_if.master        imem,
    input  wire logic            pc_write,
    input  wire logic            retain_if_id,
    input  wire logic            flush_if_id,
    input  wire logic            redirect_valid,
    input  wire logic [XLEN-1:0] redirect_pc,
    output logic                 if_id_valid,
    output logic [XLEN-1:0]      if_id_pc,
    output logic [XLEN-1:0]      if_id_instr
);

    // Counter width covers 0..DEPTH; pointer width covers 0..DEPTH-1.
    localparam int              c_CW      = $clog2(DEPTH + 1);
    localparam int              c_PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [c_CW:0]   c_DEPTH_W = (c_CW + 1)'(DEPTH);
    localparam logic [c_PW-1:0] c_LAST    = c_PW'(DEPTH - 1);
    localparam logic [XLEN-1:0] c_NOP     = XLEN'(32'h0000_0013);
    localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

    // Circular pointer advance that also works for non-power-of-two depths.
    function automatic logic [c_PW-1:0] ptr_inc(input logic [c_PW-1:0] p);
        return (p == c_LAST) ? '0 : p + c_PW'(1);
    endfunction

    // Architectural state
    logic [XLEN-1:0] r_pc;
    logic [c_CW-1:0] r_outstanding;   // all requests in flight, stale included
    logic [c_CW-1:0] r_drop_cnt;      // in-flight requests issued before a redirect
    logic [c_CW-1:0] r_count;         // prefetch FIFO occupancy

    // In-order tag queue: PC of every live in-flight request
    logic [XLEN-1:0] r_tag [DEPTH];
    logic [c_PW-1:0] r_tag_rd;
    logic [c_PW-1:0] r_tag_wr;

    // Prefetch FIFO of {pc, instr}
    logic [XLEN-1:0] r_fifo_pc    [DEPTH];
    logic [XLEN-1:0] r_fifo_instr [DEPTH];
    logic [c_PW-1:0] r_fifo_rd;
    logic [c_PW-1:0] r_fifo_wr;

    // IF/ID pipeline register
    logic            r_if_id_valid;
    logic [XLEN-1:0] r_if_id_pc;
    logic [XLEN-1:0] r_if_id_instr;

    // Combinational control
    logic w_credit_ok;
    logic w_req_valid;
    logic w_req_fire;
    logic w_rsp_valid;
    logic w_rsp_drop;
    logic w_rsp_keep;
    logic w_push;
    logic w_pop;

    // Credit counts stale requests too, so the FIFO can never overflow.
    assign w_credit_ok = ({1'b0, r_outstanding} + {1'b0, r_count}) < c_DEPTH_W;

    // Request valid depends only on state, pc_write and redirect_valid, never
    // on ready. It is forced low while reset is asserted.
    assign w_req_valid = rst_n & pc_write & ~redirect_valid & w_credit_ok;
    assign w_req_fire  = w_req_valid & imem.imem_req_ready;

    assign w_rsp_valid = imem.imem_rsp_valid;
    assign w_rsp_drop  = w_rsp_valid & (r_drop_cnt != '0);
    assign w_rsp_keep  = w_rsp_valid & (r_drop_cnt == '0);

    // A kept response in a redirect cycle belongs to the old path and is lost
    // with the FIFO clear.
    assign w_push = w_rsp_keep & ~redirect_valid;

    // Pop uses occupancy at the start of the cycle. A response landing in an
    // empty FIFO therefore reaches IF/ID one cycle later.
    assign w_pop  = ~redirect_valid & ~flush_if_id & ~retain_if_id & (r_count != '0);

    assign imem.imem_req_valid = w_req_valid;
    assign imem.imem_req_addr  = r_pc;

    assign if_id_valid = r_if_id_valid;
    assign if_id_pc    = r_if_id_pc;
    assign if_id_instr = r_if_id_instr;

    // PC: jumps to the redirect target, otherwise advances on each accepted fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= redirect_pc;
        end else if (w_req_fire) begin
            r_pc <= r_pc + c_PC_STEP;
        end
    end

    // Outstanding counter: +1 per accepted request, -1 per response of any kind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outstanding <= '0;
        end else if (w_req_fire && !w_rsp_valid) begin
            r_outstanding <= r_outstanding + c_CW'(1);
        end else if (!w_req_fire && w_rsp_valid) begin
            r_outstanding <= r_outstanding - c_CW'(1);
        end
    end

    // Drop counter: on redirect, every request still in flight after this
    // cycle becomes stale. Each later response retires one stale request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (redirect_valid) begin
            r_drop_cnt <= w_rsp_valid ? (r_outstanding - c_CW'(1)) : r_outstanding;
        end else if (w_rsp_drop) begin
            r_drop_cnt <= r_drop_cnt - c_CW'(1);
        end
    end

    // Tag queue pointers: write on issue, read on each kept response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_rd <= '0;
            r_tag_wr <= '0;
        end else if (redirect_valid) begin
            r_tag_rd <= '0;
            r_tag_wr <= '0;
        end else begin
            if (w_req_fire) begin
                r_tag_wr <= ptr_inc(r_tag_wr);
            end
            if (w_rsp_keep) begin
                r_tag_rd <= ptr_inc(r_tag_rd);
            end
        end
    end

    // FIFO pointers and occupancy: cleared on redirect, otherwise push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fifo_rd <= '0;
            r_fifo_wr <= '0;
            r_count   <= '0;
        end else if (redirect_valid) begin
            r_fifo_rd <= '0;
            r_fifo_wr <= '0;
            r_count   <= '0;
        end else begin
            if (w_push) begin
                r_fifo_wr <= ptr_inc(r_fifo_wr);
            end
            if (w_pop) begin
                r_fifo_rd <= ptr_inc(r_fifo_rd);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CW'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CW'(1);
            end
        end
    end

    // Storage arrays need no reset; validity comes from the pointers and counts.
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            r_tag[r_tag_wr] <= r_pc;
        end
        if (w_push) begin
            r_fifo_pc[r_fifo_wr]    <= r_tag[r_tag_rd];
            r_fifo_instr[r_fifo_wr] <= imem.imem_rsp_data;
        end
    end

    // IF/ID register in priority order: redirect, flush, retain, then load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_if_id_valid <= 1'b0;
            r_if_id_pc    <= '0;
            r_if_id_instr <= c_NOP;
        end else if (redirect_valid || flush_if_id) begin
            r_if_id_valid <= 1'b0;
            r_if_id_instr <= c_NOP;
        end else if (!retain_if_id) begin
            if (r_count != '0) begin
                r_if_id_valid <= 1'b1;
                r_if_id_pc    <= r_fifo_pc[r_fifo_rd];
                r_if_id_instr <= r_fifo_instr[r_fifo_rd];
            end else begin
                r_if_id_valid <= 1'b0;
                r_if_id_instr <= c_NOP;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Randomized bench for fetch_stage. A behavioural memory holds
//               a queue of pending requests with random latency. A reference
//               model tracks the program-order PC stream, a path epoch for
//               stale-response detection, a queue for the prefetch buffer and
//               the IF/ID contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_write = 1'b0;
    logic        retain_if_id = 1'b0;
    logic        flush_if_id = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;

    fetch_stage_if #(.XLEN(XLEN)) imem ();

    fetch_stage #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imem),
        .pc_write       (pc_write),
        .retain_if_id   (retain_if_id),
        .flush_if_id    (flush_if_id),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_pc       (if_id_pc),
        .if_id_instr    (if_id_instr)
    );

    always #5 clk = ~clk;

    // Pending memory request: PC the model expects, address seen on the bus,
    // path epoch at issue time, earliest cycle the response may be returned.
    typedef struct {
        logic [31:0] exp_pc;
        logic [31:0] bus_addr;
        int          epoch;
        int          due;
    } mreq_t;

    mreq_t       mem_q[$];
    logic [31:0] buf_q[$];      // model of buffered, still-useful instructions (by PC)
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_issue_pc;
    int          epoch = 0;
    int          cyc = 0;

    // Stimulus knobs (percent probabilities and latency range)
    int          p_pcw, p_ret, p_flush, p_redir, p_ready, lat_lo, lat_hi;
    logic [31:0] redir_base;
    logic        f_redir = 1'b0;
    logic [31:0] f_target = '0;

    int n_cmp = 0;
    int n_bad = 0;

    // Memory content: a position-dependent scramble so pc/instr mix-ups show.
    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic rnd(input int pct);
        return ($urandom_range(0, 99) < pct);
    endfunction

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_knobs(input int pcw, input int ret, input int fl, input int rd,
                             input int rdy, input int llo, input int lhi);
        p_pcw = pcw; p_ret = ret; p_flush = fl; p_redir = rd;
        p_ready = rdy; lat_lo = llo; lat_hi = lhi;
    endtask

    task automatic model_reset();
        mem_q.delete();
        buf_q.delete();
        m_valid    = 1'b0;
        m_pc       = '0;
        m_instr    = c_NOP;
        m_issue_pc = RESET_PC;
        epoch++;
    endtask

    // One clock cycle: check registered outputs, drive inputs, check the
    // request channel, then advance the model by what the coming edge does.
    task automatic step();
        logic        rsp, useful, rdy, pcw, ret, fl, rd, exp_rv, fire;
        logic [31:0] rpc, rsp_pc;
        @(negedge clk);
        check_value("if_id_valid", 32'(if_id_valid), 32'(m_valid));
        check_value("if_id_instr", if_id_instr, m_instr);
        if (m_valid) check_value("if_id_pc", if_id_pc, m_pc);

        pcw = rnd(p_pcw);
        ret = rnd(p_ret);
        fl  = rnd(p_flush);
        rd  = f_redir | rnd(p_redir);
        rpc = f_redir ? f_target : (redir_base + 32'($urandom_range(0, 63)) * 32'd4);
        f_redir = 1'b0;
        rdy = rnd(p_ready);
        rsp = (mem_q.size() > 0) && (mem_q[0].due <= cyc);

        pc_write            = pcw;
        retain_if_id        = ret;
        flush_if_id         = fl;
        redirect_valid      = rd;
        redirect_pc         = rpc;
        imem.imem_req_ready = rdy;
        imem.imem_rsp_valid = rsp;
        imem.imem_rsp_data  = rsp ? instr_of(mem_q[0].bus_addr) : 32'hDEAD_BEEF;
        #1;
        exp_rv = pcw && !rd && ((mem_q.size() + buf_q.size()) < DEPTH);
        check_value("req_valid", 32'(imem.imem_req_valid), 32'(exp_rv));
        if (exp_rv) check_value("req_addr", imem.imem_req_addr, m_issue_pc);
        fire = imem.imem_req_valid && rdy;

        useful = 1'b0;
        rsp_pc = '0;
        if (rsp) begin
            useful = (mem_q[0].epoch == epoch) && !rd;
            rsp_pc = mem_q[0].exp_pc;
            void'(mem_q.pop_front());
        end

        if (rd || fl) begin
            m_valid = 1'b0;
            m_instr = c_NOP;
        end else if (!ret) begin
            if (buf_q.size() > 0) begin
                m_valid = 1'b1;
                m_pc    = buf_q.pop_front();
                m_instr = instr_of(m_pc);
            end else begin
                m_valid = 1'b0;
                m_instr = c_NOP;
            end
        end

        if (rd) begin
            buf_q.delete();
            epoch++;
            m_issue_pc = rpc;
        end else if (useful) begin
            buf_q.push_back(rsp_pc);
        end

        if (fire) begin
            mem_q.push_back('{exp_pc: m_issue_pc, bus_addr: imem.imem_req_addr, epoch: epoch,
                              due: cyc + $urandom_range(lat_lo, lat_hi)});
            m_issue_pc = m_issue_pc + 32'd4;
        end
        cyc++;
    endtask

    task automatic quiet_inputs();
        pc_write            = 1'b0;
        retain_if_id        = 1'b0;
        flush_if_id         = 1'b0;
        redirect_valid      = 1'b0;
        imem.imem_req_ready = 1'b0;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        logic save;
        save = pc_write;
        pc_write = 1'b1;
        #1;
        check_value({tag, "_valid"}, 32'(if_id_valid), 32'd0);
        check_value({tag, "_pc"}, if_id_pc, 32'd0);
        check_value({tag, "_instr"}, if_id_instr, c_NOP);
        check_value({tag, "_req_valid"}, 32'(imem.imem_req_valid), 32'd0);
        pc_write = save;
    endtask

    initial begin
        quiet_inputs();
        model_reset();
        redir_base = 32'h0000_0400;
        set_knobs(100, 0, 0, 0, 100, 1, 1);

        // Reset state, held for a few edges.
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        quiet_inputs();
        rst_n = 1'b1;

        // Free run with 1-cycle memory.
        repeat (30) step();

        // Load-use stall for 3 cycles, then resume.
        set_knobs(0, 100, 0, 0, 100, 1, 1);
        repeat (3) step();
        set_knobs(100, 0, 0, 0, 100, 1, 1);
        repeat (15) step();

        // Redirect to 0x100 while two requests are in flight (3-cycle memory).
        set_knobs(100, 0, 0, 0, 100, 3, 3);
        for (int i = 0; i < 20 && mem_q.size() != 2; i++) step();
        check_value("two_in_flight", 32'(mem_q.size()), 32'd2);
        f_redir = 1'b1;
        f_target = 32'h0000_0100;
        repeat (20) step();

        // Redirect in the same cycle as a response.
        set_knobs(100, 0, 0, 0, 100, 1, 2);
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 20; i++) begin
                if (mem_q.size() > 0 && mem_q[0].due <= cyc && mem_q.size() >= 1) begin
                    f_redir = 1'b1;
                    f_target = 32'h0000_0200 + 32'(k) * 32'h40;
                    step();
                    break;
                end
                step();
            end
            repeat (6) step();
        end

        // Back-pressure across the 32-bit wrap.
        set_knobs(100, 0, 0, 0, 50, 1, 3);
        f_redir = 1'b1;
        f_target = 32'hFFFF_FFF8;
        repeat (40) step();

        // Random mix of stalls, flushes, redirects and latencies.
        redir_base = 32'hFFFF_FF00;
        set_knobs(80, 20, 10, 4, 70, 1, 4);
        repeat (1500) step();

        // Async reset between clock edges, mid-stream.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        quiet_inputs();
        check_reset_outputs("arst");
        model_reset();
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("arst_hold");
        rst_n = 1'b1;
        set_knobs(100, 0, 0, 0, 100, 1, 1);
        repeat (20) step();
        set_knobs(80, 20, 10, 4, 70, 1, 4);
        repeat (400) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
